// File: rtl/multu_hilo_unit.sv
// Radix-2 shift-add unsigned multiplier with HI/LO registers.
// Serves MULTU, MFHI and MFLO beside the EX-stage ALU.
module multu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             sel_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt;
    logic               last;
    logic               load;

    // Carry is kept in sum[WIDTH] and lands in the top bit after the shift.
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            sum = sum + {1'b0, mcand};
        end
        prod_step = {sum, prod[WIDTH-1:1]};
        last      = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                mcand <= dataA;
                prod  <= {{WIDTH{1'b0}}, dataB};
                cnt   <= '0;
            end else if (state == RUN) begin
                prod <= prod_step;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    {hi, lo} <= prod_step;
                end
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign rd_data = sel_hi ? hi : lo;

endmodule
